// File: rtl/echo_request_input_if.sv
// Request-side portal bus for the Echo demarshaller: software-facing
// message-size query and request channels, plus the user-facing say/say2
// invocation handshakes and the overflow drop counter.
interface echo_request_input_if;
    logic [15:0] portalIfc_messageSize_size_methodNumber;
    logic [15:0] portalIfc_messageSize_size;
    logic        RDY_portalIfc_messageSize_size;

    logic [31:0] portalIfc_requests_0_enq_v;
    logic        EN_portalIfc_requests_0_enq;
    logic        RDY_portalIfc_requests_0_enq;
    logic        portalIfc_requests_0_notFull;
    logic        RDY_portalIfc_requests_0_notFull;

    logic [31:0] portalIfc_requests_1_enq_v;
    logic        EN_portalIfc_requests_1_enq;
    logic        RDY_portalIfc_requests_1_enq;
    logic        portalIfc_requests_1_notFull;
    logic        RDY_portalIfc_requests_1_notFull;

    logic [31:0] ifc_say_v;
    logic        EN_ifc_say;
    logic        RDY_ifc_say;

    logic [15:0] ifc_say2_a;
    logic [15:0] ifc_say2_b;
    logic        EN_ifc_say2;
    logic        RDY_ifc_say2;

    logic [15:0] drop_count;

    // Demarshaller side
    modport slave (
        input  portalIfc_messageSize_size_methodNumber,
        output portalIfc_messageSize_size,
        output RDY_portalIfc_messageSize_size,
        input  portalIfc_requests_0_enq_v,
        input  EN_portalIfc_requests_0_enq,
        output RDY_portalIfc_requests_0_enq,
        output portalIfc_requests_0_notFull,
        output RDY_portalIfc_requests_0_notFull,
        input  portalIfc_requests_1_enq_v,
        input  EN_portalIfc_requests_1_enq,
        output RDY_portalIfc_requests_1_enq,
        output portalIfc_requests_1_notFull,
        output RDY_portalIfc_requests_1_notFull,
        output ifc_say_v,
        output EN_ifc_say,
        input  RDY_ifc_say,
        output ifc_say2_a,
        output ifc_say2_b,
        output EN_ifc_say2,
        input  RDY_ifc_say2,
        output drop_count
    );

    // Portal control / user module side
    modport master (
        output portalIfc_messageSize_size_methodNumber,
        input  portalIfc_messageSize_size,
        input  RDY_portalIfc_messageSize_size,
        output portalIfc_requests_0_enq_v,
        output EN_portalIfc_requests_0_enq,
        input  RDY_portalIfc_requests_0_enq,
        input  portalIfc_requests_0_notFull,
        input  RDY_portalIfc_requests_0_notFull,
        output portalIfc_requests_1_enq_v,
        output EN_portalIfc_requests_1_enq,
        input  RDY_portalIfc_requests_1_enq,
        input  portalIfc_requests_1_notFull,
        input  RDY_portalIfc_requests_1_notFull,
        input  ifc_say_v,
        input  EN_ifc_say,
        output RDY_ifc_say,
        input  ifc_say2_a,
        input  ifc_say2_b,
        input  EN_ifc_say2,
        output RDY_ifc_say2,
        input  drop_count
    );
endinterface

// File: rtl/echo_request_input.sv
// Echo request demarshaller: two independent per-method FIFOs (say, say2)
// that buffer request words and dispatch them to the user module with a
// ready/enable handshake. No bypass path: a word is visible one cycle
// after it is enqueued, and a full FIFO refuses words even while popping.
module echo_request_input #(
    parameter int DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    echo_request_input_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = 1;
    localparam logic [PW:0]   CNT_ONE    = 1;
    localparam logic [PW:0]   FULL_COUNT = DEPTH;

    // Channel-indexed views of the bus so both channels share one generate body
    logic [1:0][31:0] enq_word;
    logic [1:0][31:0] head_word;
    logic [1:0]       enq_strobe;
    logic [1:0]       down_rdy;
    logic [1:0]       not_full;
    logic [1:0]       not_empty;
    logic [1:0]       overflow;

    assign enq_word[0]   = bus.portalIfc_requests_0_enq_v;
    assign enq_word[1]   = bus.portalIfc_requests_1_enq_v;
    assign enq_strobe[0] = bus.EN_portalIfc_requests_0_enq;
    assign enq_strobe[1] = bus.EN_portalIfc_requests_1_enq;
    assign down_rdy[0]   = bus.RDY_ifc_say;
    assign down_rdy[1]   = bus.RDY_ifc_say2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [31:0]   mem_q [DEPTH];
            logic [PW-1:0] wptr_q, wptr_d;
            logic [PW-1:0] rptr_q, rptr_d;
            logic [PW:0]   count_q, count_d;
            logic          push;
            logic          pop;

            // Full/empty come only from the registered count, so the
            // enqueue-ready outputs have no combinational input path.
            assign not_full[gi]  = (count_q != FULL_COUNT);
            assign not_empty[gi] = (count_q != '0);
            assign push          = enq_strobe[gi] & not_full[gi];
            assign pop           = not_empty[gi] & down_rdy[gi];
            assign overflow[gi]  = enq_strobe[gi] & ~not_full[gi];
            assign head_word[gi] = mem_q[rptr_q];

            // Next-state for pointers and occupancy; pointers wrap naturally
            // because DEPTH is a power of two.
            always_comb begin
                wptr_d  = wptr_q;
                rptr_d  = rptr_q;
                count_d = count_q;
                if (push) begin
                    wptr_d = wptr_q + PTR_ONE;
                end
                if (pop) begin
                    rptr_d = rptr_q + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end

            // Pointer/count state; asynchronous clear discards queued words
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    wptr_q  <= '0;
                    rptr_q  <= '0;
                    count_q <= '0;
                end else begin
                    wptr_q  <= wptr_d;
                    rptr_q  <= rptr_d;
                    count_q <= count_d;
                end
            end

            // Storage write; contents are not cleared on reset
            always_ff @(posedge CLK) begin
                if (push) begin
                    mem_q[wptr_q] <= enq_word[gi];
                end
            end
        end
    endgenerate

    // Drop counter: both channels may overflow in one cycle, saturating at all-ones
    logic [15:0] drop_count_q, drop_count_d;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    always_comb begin
        drop_inc     = {1'b0, overflow[0]} + {1'b0, overflow[1]};
        drop_sum     = {1'b0, drop_count_q} + {15'b0, drop_inc};
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Drop counter register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    // Payload size lookup: both methods carry one 32-bit word
    always_comb begin
        case (bus.portalIfc_messageSize_size_methodNumber)
            16'd0, 16'd1: bus.portalIfc_messageSize_size = 16'd32;
            default:      bus.portalIfc_messageSize_size = 16'd0;
        endcase
    end

    assign bus.RDY_portalIfc_messageSize_size   = 1'b1;

    assign bus.RDY_portalIfc_requests_0_enq     = not_full[0];
    assign bus.portalIfc_requests_0_notFull     = not_full[0];
    assign bus.RDY_portalIfc_requests_0_notFull = 1'b1;
    assign bus.RDY_portalIfc_requests_1_enq     = not_full[1];
    assign bus.portalIfc_requests_1_notFull     = not_full[1];
    assign bus.RDY_portalIfc_requests_1_notFull = 1'b1;

    assign bus.ifc_say_v   = head_word[0];
    assign bus.EN_ifc_say  = not_empty[0] & down_rdy[0];
    assign bus.ifc_say2_a  = head_word[1][31:16];
    assign bus.ifc_say2_b  = head_word[1][15:0];
    assign bus.EN_ifc_say2 = not_empty[1] & down_rdy[1];

    assign bus.drop_count  = drop_count_q;
endmodule

// File: doc/echo_request_input.md
# echo_request_input

Request-side portal demarshaller for the Echo example: the inverse of the indication output path. Software request words arrive on two per-method request channels (method 0 `say`, method 1 `say2`). Each channel buffers its words in a small FIFO, unpacks each word into method arguments, and invokes the corresponding user method with a ready/enable handshake. The block sits between the portal control/MMIO logic and the Echo user module.

## Interface
- `DEPTH`, 2: entries per request FIFO; power of two, ≥ 2.
- `CLK` in 1: single clock domain.
- `RST_N` in 1: reset, asynchronous assert, active-low; all state clears while low.
- `portalIfc_messageSize_size_methodNumber` in 16: method number to query.
- `portalIfc_messageSize_size` out 16: payload bit count for the queried method.
- `RDY_portalIfc_messageSize_size` out 1: constant 1.
- `portalIfc_requests_0_enq_v` in 32: `say` request word.
- `EN_portalIfc_requests_0_enq` in 1: enqueue strobe for channel 0.
- `RDY_portalIfc_requests_0_enq` out 1: channel 0 FIFO not full.
- `portalIfc_requests_0_notFull` out 1: same as `RDY_portalIfc_requests_0_enq`.
- `RDY_portalIfc_requests_0_notFull` out 1: constant 1.
- `portalIfc_requests_1_enq_v`, `EN_portalIfc_requests_1_enq`, `RDY_portalIfc_requests_1_enq`, `portalIfc_requests_1_notFull`, `RDY_portalIfc_requests_1_notFull`: same set of ports for the `say2` channel (channel 1).
- `ifc_say_v` out 32: `say` argument, taken from the head of FIFO 0.
- `EN_ifc_say` out 1: `say` invocation strobe.
- `RDY_ifc_say` in 1: user module can accept `say`.
- `ifc_say2_a` out 16, `ifc_say2_b` out 16: `say2` arguments, taken from the head of FIFO 1.
- `EN_ifc_say2` out 1: `say2` invocation strobe.
- `RDY_ifc_say2` in 1: user module can accept `say2`.
- `drop_count` out 16: count of enqueue strobes that arrived while the target FIFO was full.

## Operation
- Message size lookup is combinational:
  - method 0 → 32
  - method 1 → 32
  - any other method → 0
- Each channel has a circular FIFO with `DEPTH` entries, read/write pointers of log2(`DEPTH`) bits, and a count register of log2(`DEPTH`)+1 bits.
- Enqueue: accepted when EN is high and the FIFO is not full. The word is written at the write pointer, which then increments mod `DEPTH`.
- Enqueue while full: the word is dropped, FIFO contents are unchanged, and `drop_count` increments. `drop_count` saturates at 0xFFFF.
- If both channels overflow in the same cycle, `drop_count` increments by 2, still saturating.
- Dispatch for channel 0: `EN_ifc_say` = (FIFO 0 not empty) AND `RDY_ifc_say`. When it is high, the head entry pops in the same cycle.
- `say2` unpacking: `ifc_say2_a` = word[31:16] and `ifc_say2_b` = word[15:0]. Its dispatch rule is identical to channel 0.
- The two channels are fully independent; both may dispatch in the same cycle.
- Data outputs always show the FIFO head, and are don't-care when the FIFO is empty.
- Simultaneous enqueue and pop on a non-full, non-empty FIFO: both take effect and the count is unchanged.
- No bypass:
  - When empty, an incoming word is not visible until the next cycle.
  - When full, an enqueue in the same cycle as a pop is still rejected, because RDY was low.

## Timing
- Enqueue-to-dispatch latency is 1 cycle minimum: a word enqueued at edge N can raise EN at cycle N+1 if RDY is high.
- Sustained throughput is 1 word/cycle per channel when `DEPTH` ≥ 2 and the downstream RDY stays high.
- `RDY_*_enq` and `notFull` depend only on registered count (no combinational path from any input).
- `EN_ifc_*` depends combinationally on `RDY_ifc_*` only.
- Reset values:
  - all pointers and counts = 0
  - `RDY_*_enq` = 1, `notFull` = 1
  - `EN_ifc_say` = `EN_ifc_say2` = 0
  - `drop_count` = 0
  - FIFO storage is not reset
- Reset asserted mid-stream discards all queued words immediately (asynchronous). No EN is issued in the cycle after deassertion.

## Test plan
- Reset, then enqueue 0xDEADBEEF on channel 0 with `RDY_ifc_say`=1 → next cycle `EN_ifc_say`=1 and `ifc_say_v`=0xDEADBEEF for exactly 1 cycle.
- Enqueue 0x12345678 on channel 1 → `EN_ifc_say2`=1 with `ifc_say2_a`=0x1234 and `ifc_say2_b`=0x5678.
- Hold `RDY_ifc_say`=0 and enqueue 3 words with `DEPTH`=2:
  - after 2 words, `RDY_portalIfc_requests_0_enq`=0
  - the 3rd word is dropped and `drop_count`=1
  - raise RDY → only the first 2 words are dispatched, in order
- Stream 100 back-to-back words on both channels with both RDYs high:
  - each channel dispatches 1 word per cycle, in order
  - `drop_count` stays 0
- `messageSize` queries:
  - methodNumber 0 → 32
  - methodNumber 1 → 32
  - methodNumber 7 → 0
- Fill channel 0, pull `RST_N` low mid-cycle:
  - `notFull`=1 immediately
  - after release, no `EN_ifc_say` occurs until a new enqueue
